// File: rtl/uart_pkg.sv
// Shared definitions for the UART frame parser: FSM state encoding,
// error codes reported on err_code, and the default frame delimiter.
package uart_pkg;

  // Parser states; IDLE must stay at zero so busy is simply "state != IDLE"
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    PAYLOAD = 2'b01,
    CHKSUM  = 2'b10
  } state_t;

  // Error codes held on err_code until the next frame result
  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_CHKSUM  = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  // Byte value that opens a command frame
  localparam logic [7:0] DEFAULT_START_BYTE = 8'h3A;

endpackage

// File: rtl/uart_frame_timeout.sv
// Inter-byte timeout counter for the UART frame parser.
// Counts cycles while i_run is high, restarts on i_clear, and flags
// o_expired during the last cycle of the allowed gap.
module uart_frame_timeout #(
  parameter int TIMEOUT_CYCLES = 500_000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_run,
  output logic o_expired
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] r_count;

  // Gap counter: cleared by any byte or while idle, otherwise advances while a frame is open
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_count <= '0;
    end else if (i_run) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = i_run && (r_count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/uart_frame_parser.sv
// UART command frame parser: START_BYTE, PAYLOAD_BYTES data bytes, XOR checksum.
// Validated payloads appear on payload with a one-cycle frame_valid pulse;
// bad frames raise a one-cycle frame_error pulse with a held err_code.
// Optional feature macro: UART_FRAME_TIMEOUT_EN (inter-byte timeout, err_code 2'b10).
module uart_frame_parser
  import uart_pkg::*;
#(
  parameter int                N_BITS        = 8,
  parameter int                PAYLOAD_BYTES = 4,
  parameter logic [N_BITS-1:0] START_BYTE    = N_BITS'(DEFAULT_START_BYTE),
  parameter int                CLOCK_HZ      = 50_000_000,
  parameter int                TIMEOUT_MS    = 10
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            byte_valid,
  input  logic [N_BITS-1:0]               byte_in,
  output logic                            frame_valid,
  output logic                            frame_error,
  output logic [1:0]                      err_code,
  output logic [PAYLOAD_BYTES*N_BITS-1:0] payload,
  output logic                            busy
);

  localparam int PW = PAYLOAD_BYTES * N_BITS;
  localparam int CW = $clog2(PAYLOAD_BYTES + 1);

  state_t          r_state, w_nextState;
  logic [CW-1:0]   r_count, w_nextCount;
  logic [N_BITS-1:0] r_acc, w_nextAcc;
  logic [PW-1:0]   r_shadow, w_nextShadow;
  logic [PW-1:0]   r_payload, w_nextPayload;
  logic            r_frameValid, w_nextFrameValid;
  logic            r_frameError, w_nextFrameError;
  logic [1:0]      r_errCode, w_nextErrCode;
  logic [PW+N_BITS-1:0] w_shiftExt;

  // Shadow shifted left by one byte with the new byte in the LSBs
  assign w_shiftExt = {r_shadow, byte_in};

`ifdef UART_FRAME_TIMEOUT_EN
  localparam int TIMEOUT_CYCLES = CLOCK_HZ / 1000 * TIMEOUT_MS;

  logic w_timeoutExpired;

  uart_frame_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (byte_valid || (r_state == IDLE)),
    .i_run    (r_state != IDLE),
    .o_expired(w_timeoutExpired)
  );
`endif

  // Register all parser state; reset aborts any frame silently and clears payload
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_count      <= '0;
      r_acc        <= '0;
      r_shadow     <= '0;
      r_payload    <= '0;
      r_frameValid <= 1'b0;
      r_frameError <= 1'b0;
      r_errCode    <= ERR_NONE;
    end else begin
      r_state      <= w_nextState;
      r_count      <= w_nextCount;
      r_acc        <= w_nextAcc;
      r_shadow     <= w_nextShadow;
      r_payload    <= w_nextPayload;
      r_frameValid <= w_nextFrameValid;
      r_frameError <= w_nextFrameError;
      r_errCode    <= w_nextErrCode;
    end
  end

  // Next-state and datapath decisions; a byte always takes priority over an expiring gap
  always_comb begin
    w_nextState      = r_state;
    w_nextCount      = r_count;
    w_nextAcc        = r_acc;
    w_nextShadow     = r_shadow;
    w_nextPayload    = r_payload;
    w_nextFrameValid = 1'b0;
    w_nextFrameError = 1'b0;
    w_nextErrCode    = r_errCode;

    case (r_state)
      IDLE: begin
        if (byte_valid && (byte_in == START_BYTE)) begin
          w_nextCount = '0;
          w_nextAcc   = '0;
          w_nextState = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (byte_valid) begin
          w_nextShadow = w_shiftExt[PW-1:0];
          w_nextAcc    = r_acc ^ byte_in;
          w_nextCount  = r_count + 1'b1;
          if (r_count == CW'(PAYLOAD_BYTES - 1)) begin
            w_nextState = CHKSUM;
          end
        end
      end
      CHKSUM: begin
        if (byte_valid) begin
          if (byte_in == r_acc) begin
            w_nextPayload    = r_shadow;
            w_nextFrameValid = 1'b1;
            w_nextErrCode    = ERR_NONE;
          end else begin
            w_nextFrameError = 1'b1;
            w_nextErrCode    = ERR_CHKSUM;
          end
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase

`ifdef UART_FRAME_TIMEOUT_EN
    if (w_timeoutExpired && !byte_valid) begin
      w_nextState      = IDLE;
      w_nextFrameError = 1'b1;
      w_nextErrCode    = ERR_TIMEOUT;
    end
`endif
  end

  assign frame_valid = r_frameValid;
  assign frame_error = r_frameError;
  assign err_code    = r_errCode;
  assign payload     = r_payload;
  assign busy        = (r_state != IDLE);

endmodule
